// File: rtl/lpf_pkg.sv
// Shared definitions for the low-pass filter coefficient generator:
// FSM states, exponential LUT geometry and the default data width.
package lpf_pkg;

  localparam int LPF_W_DEF  = 32'd16;
  localparam int LUT_DEPTH  = 32'd64;
  localparam int LUT_IDX_W  = 32'd6;
  localparam int LUT_FRAC_W = 32'd9;

  localparam logic [LUT_IDX_W-1:0] LUT_LAST_IDX = 6'd63;
  localparam logic [LUT_IDX_W-1:0] LUT_IDX_ONE  = 6'd1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_INTERP = 3'd2,
    ST_SMOOTH = 3'd3,
    ST_DONE   = 3'd4
  } lpf_state_e;

endpackage

// File: rtl/lpf_coeff_gen_if.sv
// Control-voltage in / coefficient out bundle between the CV source
// (master) and the coefficient generator (slave).
interface lpf_coeff_gen_if import lpf_pkg::*; #(parameter int W = LPF_W_DEF);

  logic                sample_strobe;
  logic signed [W-1:0] cutoff_cv;
  logic signed [W-1:0] resonance_cv;
  logic signed [W-1:0] g;
  logic signed [W-1:0] resonance;
  logic                coeff_valid;
  logic                overrun;

  modport master (
    output sample_strobe, cutoff_cv, resonance_cv,
    input  g, resonance, coeff_valid, overrun
  );

  modport slave (
    input  sample_strobe, cutoff_cv, resonance_cv,
    output g, resonance, coeff_valid, overrun
  );

endinterface

// File: rtl/lpf_exp_rom.sv
// 64-entry exponential table t[i] = round(32767 * 2^((i-63)/8)); returns
// t[idx] and t[idx+1], with the top entry repeated instead of wrapping.
module lpf_exp_rom import lpf_pkg::*; #(
  parameter int W = LPF_W_DEF
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [W-1:0]         t_lo,
  output logic [W-1:0]         t_hi
);

  localparam logic [15:0] EXP_LUT [LUT_DEPTH] = '{
    16'd140,   16'd152,   16'd166,   16'd181,   16'd197,   16'd215,   16'd235,   16'd256,
    16'd279,   16'd304,   16'd332,   16'd362,   16'd395,   16'd431,   16'd469,   16'd512,
    16'd558,   16'd609,   16'd664,   16'd724,   16'd790,   16'd861,   16'd939,   16'd1024,
    16'd1117,  16'd1218,  16'd1328,  16'd1448,  16'd1579,  16'd1722,  16'd1878,  16'd2048,
    16'd2233,  16'd2435,  16'd2656,  16'd2896,  16'd3158,  16'd3444,  16'd3756,  16'd4096,
    16'd4467,  16'd4871,  16'd5312,  16'd5792,  16'd6317,  16'd6888,  16'd7512,  16'd8192,
    16'd8933,  16'd9742,  16'd10623, 16'd11585, 16'd12633, 16'd13777, 16'd15024, 16'd16384,
    16'd17866, 16'd19483, 16'd21247, 16'd23170, 16'd25267, 16'd27554, 16'd30047, 16'd32767
  };

  logic [LUT_IDX_W-1:0] idx_hi_s;

  // Upper neighbour index, pinned at the last entry.
  always_comb begin
    if (idx == LUT_LAST_IDX) begin
      idx_hi_s = idx;
    end else begin
      idx_hi_s = idx + LUT_IDX_ONE;
    end
    t_lo = W'(EXP_LUT[idx]);
    t_hi = W'(EXP_LUT[idx_hi_s]);
  end

endmodule

// File: rtl/lpf_coeff_gen.sv
// Cutoff/resonance coefficient generator for a ladder filter: latch, LUT lookup,
// linear interpolation, optional one-pole smoothing (macro LPF_COEFF_SLEW_EN).
module lpf_coeff_gen import lpf_pkg::*; #(
  parameter int W          = LPF_W_DEF,
  parameter int SLEW_SHIFT = 32'd4
) (
  input  logic                   clk,
  input  logic                   rst,
  lpf_coeff_gen_if.slave         bus
);

  localparam logic signed [2*W-1:0] G_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};

  if (SLEW_SHIFT < 0 || SLEW_SHIFT >= 2*W) begin : g_slew_shift_range
    $error("lpf_coeff_gen: SLEW_SHIFT out of range");
  end

  lpf_state_e                state_r, state_next_s;
  logic                      latch_s, lookup_s, interp_s, smooth_s, done_s, busy_strobe_s;
  logic [LUT_IDX_W-1:0]      idx_r;
  logic [LUT_FRAC_W-1:0]     frac_r;
  logic signed [W-1:0]       res_target_r;
  logic [W-1:0]              rom_lo_s, rom_hi_s, t_lo_r, t_hi_r;
  logic signed [2*W-1:0]     lo_ext_s, hi_ext_s, frac_ext_s, prod_s, interp_sum_s;
  logic signed [W-1:0]       target_g_s, target_g_r;
  logic signed [W-1:0]       smooth_g_s, smooth_res_s;
  logic signed [W-1:0]       g_r, res_out_r;
  logic                      valid_r, overrun_r;

  lpf_exp_rom #(.W(W)) u_rom (
    .idx  (idx_r),
    .t_lo (rom_lo_s),
    .t_hi (rom_hi_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: only IDLE waits, every other state advances each clock.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.sample_strobe) begin
          state_next_s = ST_LOOKUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOOKUP: state_next_s = ST_INTERP;
      ST_INTERP: state_next_s = ST_SMOOTH;
      ST_SMOOTH: state_next_s = ST_DONE;
      ST_DONE:   state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // FSM stage enables; a strobe outside IDLE (DONE included) is an overrun.
  always_comb begin
    latch_s  = 1'b0;
    lookup_s = 1'b0;
    interp_s = 1'b0;
    smooth_s = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE:   latch_s  = bus.sample_strobe;
      ST_LOOKUP: lookup_s = 1'b1;
      ST_INTERP: interp_s = 1'b1;
      ST_SMOOTH: smooth_s = 1'b1;
      ST_DONE:   done_s   = 1'b1;
      default:   latch_s  = 1'b0;
    endcase
    busy_strobe_s = bus.sample_strobe && (state_r != ST_IDLE);
  end

  assign lo_ext_s     = {{W{1'b0}}, t_lo_r};
  assign hi_ext_s     = {{W{1'b0}}, t_hi_r};
  assign frac_ext_s   = {{(2*W-LUT_FRAC_W){1'b0}}, frac_r};
  assign prod_s       = (hi_ext_s - lo_ext_s) * frac_ext_s;
  assign interp_sum_s = lo_ext_s + (prod_s >>> LUT_FRAC_W);

  // Saturate the interpolated cutoff into [0, G_MAX].
  always_comb begin
    if (interp_sum_s[2*W-1]) begin
      target_g_s = '0;
    end else if (interp_sum_s > G_MAX) begin
      target_g_s = G_MAX[W-1:0];
    end else begin
      target_g_s = interp_sum_s[W-1:0];
    end
  end

  // Datapath: negative CVs clamp to zero at latch time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r        <= '0;
      frac_r       <= '0;
      res_target_r <= '0;
      t_lo_r       <= '0;
      t_hi_r       <= '0;
      target_g_r   <= '0;
    end else begin
      if (latch_s) begin
        idx_r        <= bus.cutoff_cv[W-1] ? '0 : bus.cutoff_cv[LUT_IDX_W+LUT_FRAC_W-1:LUT_FRAC_W];
        frac_r       <= bus.cutoff_cv[W-1] ? '0 : bus.cutoff_cv[LUT_FRAC_W-1:0];
        res_target_r <= bus.resonance_cv[W-1] ? '0 : bus.resonance_cv;
      end
      if (lookup_s) begin
        t_lo_r <= rom_lo_s;
        t_hi_r <= rom_hi_s;
      end
      if (interp_s) begin
        target_g_r <= target_g_s;
      end
    end
  end

`ifdef LPF_COEFF_SLEW_EN
  logic signed [2*W-1:0] acc_g_r, acc_res_r;

  // One-pole smoothing toward the targets, one step per update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_g_r   <= '0;
      acc_res_r <= '0;
    end else if (smooth_s) begin
      acc_g_r   <= acc_g_r + (({{W{target_g_r[W-1]}}, target_g_r} - acc_g_r) >>> SLEW_SHIFT);
      acc_res_r <= acc_res_r + (({{W{res_target_r[W-1]}}, res_target_r} - acc_res_r) >>> SLEW_SHIFT);
    end
  end

  assign smooth_g_s   = acc_g_r[W-1:0];
  assign smooth_res_s = acc_res_r[W-1:0];
`else
  assign smooth_g_s   = target_g_r;
  assign smooth_res_s = res_target_r;
`endif

  // Registered outputs: coefficients load only on the DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_r       <= '0;
      res_out_r <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      valid_r   <= done_s;
      overrun_r <= overrun_r | busy_strobe_s;
      if (done_s) begin
        g_r       <= smooth_g_s;
        res_out_r <= smooth_res_s;
      end
    end
  end

  assign bus.g           = g_r;
  assign bus.resonance   = res_out_r;
  assign bus.coeff_valid = valid_r;
  assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_lpf_coeff_gen.sv
// Self-checking bench for lpf_coeff_gen: directed boundary cases plus random CVs
// against a real-arithmetic reference of the exponential table and interpolation.
module tb_lpf_coeff_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   tbl [64];
  int   exp_g = 0;
  int   exp_res = 0;
  int   exp_ovr = 0;
  int   acc_g = 0;
  int   acc_r = 0;

  lpf_coeff_gen_if #(.W(16)) bus ();

  lpf_coeff_gen #(.W(16), .SLEW_SHIFT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int clamp0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  function automatic int model_target(input int cut);
    int c, i, f, lo, hi, r;
    c  = clamp0(cut);
    i  = c / 512;
    f  = c % 512;
    lo = tbl[i];
    hi = (i == 63) ? tbl[63] : tbl[i+1];
    r  = lo + ((hi - lo) * f) / 512;
    if (r > 32767) r = 32767;
    if (r < 0) r = 0;
    return r;
  endfunction

  task automatic run_update(input string tag, input int cut, input int res, input int dup_at);
    int first_valid, pulses, prev_g, tgt;
    first_valid = 0;
    pulses      = 0;
    prev_g      = exp_g;
    tgt         = model_target(cut);
`ifdef LPF_COEFF_SLEW_EN
    acc_g   = acc_g + ((tgt - acc_g) >>> 4);
    acc_r   = acc_r + ((clamp0(res) - acc_r) >>> 4);
    exp_g   = acc_g;
    exp_res = acc_r;
`else
    exp_g   = tgt;
    exp_res = clamp0(res);
`endif
    if (dup_at != 0) exp_ovr = 1;
    @(negedge clk);
    bus.sample_strobe = 1'b1;
    bus.cutoff_cv     = 16'(cut);
    bus.resonance_cv  = 16'(res);
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc == dup_at) begin
        bus.sample_strobe = 1'b1;
        bus.cutoff_cv     = 16'($urandom);
        bus.resonance_cv  = 16'($urandom);
      end
      @(negedge clk);
      bus.sample_strobe = 1'b0;
      if (bus.coeff_valid === 1'b1) begin
        pulses++;
        if (first_valid == 0) first_valid = cyc;
      end
      if (cyc == 3) check({tag, "_hold_g"}, bus.g, prev_g);
    end
    check({tag, "_latency"}, first_valid, 4);
    check({tag, "_pulses"}, pulses, 1);
    check({tag, "_g"}, bus.g, exp_g);
    check({tag, "_res"}, bus.resonance, exp_res);
    check({tag, "_overrun"}, bus.overrun, exp_ovr);
  endtask

  initial begin
    logic signed [15:0] r_cut, r_res;
    int                 pulses;

    for (int i = 0; i < 64; i++) begin
      tbl[i] = $rtoi(32767.0 * (2.0 ** ((real'(i) - 63.0) / 8.0)) + 0.5);
    end

    bus.sample_strobe = 1'b0;
    bus.cutoff_cv     = 16'sd0;
    bus.resonance_cv  = 16'sd0;
    repeat (3) @(negedge clk);
    check("rst_g", bus.g, 0);
    check("rst_res", bus.resonance, 0);
    check("rst_valid", bus.coeff_valid, 0);
    check("rst_overrun", bus.overrun, 0);
    rst = 1'b0;
    @(negedge clk);

    run_update("cut_zero", 0, 0, 0);
    run_update("cut_mid", 16384, 12000, 0);
    run_update("cut_max", 32767, -5, 0);
    run_update("cut_neg", -1000, 32767, 0);
    run_update("cut_idx63", 32256, 100, 0);
    run_update("cut_frac", 16640, 1, 0);

    for (int n = 0; n < 16; n++) begin
      r_cut = 16'($urandom);
      r_res = 16'($urandom);
      run_update("rand", int'(r_cut), int'(r_res), 0);
    end

    // Second strobe two clocks into a busy update.
    r_cut = 16'($urandom);
    run_update("ovr_busy", int'(r_cut), 777, 2);
    run_update("ovr_sticky", 8000, 3000, 0);

    // Reset pulse while the FSM sits in INTERP.
    @(negedge clk);
    bus.sample_strobe = 1'b1;
    bus.cutoff_cv     = 16'sd20000;
    bus.resonance_cv  = 16'sd5000;
    @(negedge clk);
    bus.sample_strobe = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_g", bus.g, 0);
    check("midrst_res", bus.resonance, 0);
    check("midrst_overrun", bus.overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (bus.coeff_valid === 1'b1) pulses++;
    end
    check("midrst_no_valid", pulses, 0);
    exp_g   = 0;
    exp_res = 0;
    exp_ovr = 0;
    acc_g   = 0;
    acc_r   = 0;
    run_update("post_rst", 24000, 9000, 0);

    // Strobe coinciding with the DONE -> IDLE transition.
    run_update("done_strobe", 12345, 4321, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lpf_coeff_gen.md
LPF_COEFF_GEN -- requirements
Module: lpf_coeff_gen

Interface
REQ-001 Parameter W, default 16: width of CV inputs and coefficient outputs.
REQ-002 Parameter SLEW_SHIFT, default 4: one-pole smoothing shift, honoured only when smoothing is compiled in.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sample_strobe  input  1  one-clk pulse per audio sample; starts a coefficient update.
REQ-006 cutoff_cv  input  W  signed cutoff control; exponential (V/oct-like) scale.
REQ-007 resonance_cv  input  W  signed resonance control.
REQ-008 g  output  W  signed cutoff coefficient for the downstream ladder filter; range [0, 32767].
REQ-009 resonance  output  W  signed resonance coefficient for the downstream ladder filter; range [0, 32767].
REQ-010 coeff_valid  output  1  one-clk pulse when g and resonance have just updated.
REQ-011 overrun  output  1  sticky flag: a strobe arrived while busy.

Function
REQ-012 FSM states: IDLE, LOOKUP, INTERP, SMOOTH, DONE; state advances by one each clk after IDLE.
REQ-013 IDLE with sample_strobe=1: latch both CVs and go to LOOKUP. IDLE with strobe=0: stay.
REQ-014 Clamping at latch: negative CV becomes 0. Positive values are unchanged, since max is 32767.
REQ-015 LOOKUP: index = clamped_cutoff[14:9] (6 bits), frac = clamped_cutoff[8:0]. Fetch t[index] and t[index+1].
REQ-016 Table: 64 entries, t[i] = round(32767 * 2^((i-63)/8)), covering 7.875 octaves. t[0]=140, t[32]=2233, t[63]=32767.
REQ-017 For index=63, t[index+1] is defined as t[63], so no wrap to t[0] occurs.
REQ-018 INTERP: target_g = t[i] + (((t[i+1]-t[i]) * frac) >>> 9), using 2W-bit signed intermediates. Saturate the result to [0, 32767].
REQ-019 SMOOTH: compute g and resonance from the targets per REQ-026/REQ-027.
REQ-020 DONE: assert coeff_valid for exactly one clk, then return to IDLE.
REQ-021 Latency: coeff_valid asserts 4 clk after the strobe edge. g and resonance change only on the DONE cycle edge and hold otherwise.
REQ-022 A strobe in any state other than IDLE is ignored, its CVs are not latched, and overrun is set to 1. overrun clears only on rst.
REQ-023 A strobe on the same cycle as DONE→IDLE is ignored (still busy) and sets overrun.

Reset
REQ-024 While rst=1: g=0, resonance=0, coeff_valid=0, overrun=0, state=IDLE, smoothing accumulators=0.
REQ-025 rst asserted mid-update aborts the update. No coeff_valid is issued for it, and the first strobe after release starts a fresh update.

Configuration
REQ-026 With macro LPF_COEFF_SLEW_EN defined, each output follows its target one-pole style: acc <= acc + ((target - acc) >>> SLEW_SHIFT), with a 2W-bit signed accumulator. The output is acc[W-1:0].
REQ-027 Without LPF_COEFF_SLEW_EN, g=target_g and resonance=clamped resonance_cv directly. SLEW_SHIFT is unused and no accumulator exists.

Structure
REQ-028 Shared package lpf_pkg holds the FSM state enum, the LUT depth/index/frac width constants, and the default W.
REQ-029 A single sub-module lpf_exp_rom holds the 64-entry constant table. It has a combinational read of two adjacent entries with the index-63 clamp.
REQ-030 The parent holds the FSM, clamping, interpolation multiply, and optional smoothing. Target size is 150-300 lines.

Verification (bench built without LPF_COEFF_SLEW_EN unless stated)
REQ-031 Strobe, cutoff_cv=0 → 4 clk later coeff_valid pulses once and g=140.
REQ-032 Strobe, cutoff_cv=16384 → g=2233. Strobe, cutoff_cv=32767 → g=32767 with no wrap. Strobe, cutoff_cv=-1000 → g=140.
REQ-033 Strobe, resonance_cv=-5 → resonance=0. Strobe, resonance_cv=12000 → resonance=12000.
REQ-034 Strobe, then a second strobe 2 clk later → only one coeff_valid, overrun=1 and held until rst. Outputs reflect the first CV.
REQ-035 With LPF_COEFF_SLEW_EN and SLEW_SHIFT=4, from reset, cutoff_cv=32767 → the first update gives g=2047, and g rises monotonically over successive strobes.
REQ-036 rst pulse during INTERP → no coeff_valid, and g=0, resonance=0, overrun=0. The next strobe completes normally after 4 clk.
